mem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the 256 x 32-bit single-port data memory. It shares the memory between the instruction-fetch requester (port 0) and the load/store requester (port 1) using round-robin priority. It drives the memory's address, write-data and write-enable lines, and returns registered read data plus an out-of-range error flag to the winning requester one cycle after grant.

---
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-port 256x32 memory between fetch (port 0) and load/store (port 1).
// Latency: the response is registered and valid 1 cycle after grant. Backpressure: a losing port holds req until it sees gnt.
module mem_arbiter #(
    parameter int MEM_WORDS = 256,
    parameter int AW        = 32,
    parameter int DW        = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic          err0,
    output logic          err1,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_write_data,
    output logic          mem_write_enable,
    input  logic [DW-1:0] mem_read_data
);

    localparam logic [AW-1:0] MEM_LIMIT = AW'(MEM_WORDS);

    logic          last_gnt_q, last_gnt_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic          err0_q, err0_d, err1_q, err1_d;

    logic          win_we;
    logic          in_range;
    logic [DW-1:0] load_data;

    always_comb begin
        gnt0           = 1'b0;
        gnt1           = 1'b0;
        win_we         = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;

        // Grant is masked by rst so a reset landing mid-transfer cannot commit a store.
        if (!rst) begin
            if (req0 && req1) begin
                gnt0 = last_gnt_q;
                gnt1 = ~last_gnt_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end

        if (gnt0) begin
            win_we         = we0;
            mem_address    = addr0;
            mem_write_data = wdata0;
        end else if (gnt1) begin
            win_we         = we1;
            mem_address    = addr1;
            mem_write_data = wdata1;
        end

        in_range         = (mem_address < MEM_LIMIT);
        mem_write_enable = (gnt0 | gnt1) & win_we & in_range;
        load_data        = (~win_we & in_range) ? mem_read_data : '0;

        last_gnt_d = last_gnt_q;
        if (gnt0) last_gnt_d = 1'b0;
        if (gnt1) last_gnt_d = 1'b1;

        rvalid0_d = gnt0;
        rvalid1_d = gnt1;
        err0_d    = gnt0 & ~in_range;
        err1_d    = gnt1 & ~in_range;
        rdata0_d  = gnt0 ? load_data : rdata0_q;
        rdata1_d  = gnt1 ? load_data : rdata1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
        end else begin
            last_gnt_q <= last_gnt_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
        end
    end

    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign err0    = err0_q;
    assign err1    = err1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256x32 memory (combinational read, clocked write).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_write_enable;
    logic        mem_clr;

    logic [31:0] mem [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_WORDS(256), .AW(32), .DW(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .req0             (req0),
        .req1             (req1),
        .we0              (we0),
        .we1              (we1),
        .addr0            (addr0),
        .addr1            (addr1),
        .wdata0           (wdata0),
        .wdata1           (wdata1),
        .gnt0             (gnt0),
        .gnt1             (gnt1),
        .rdata0           (rdata0),
        .rdata1           (rdata1),
        .rvalid0          (rvalid0),
        .rvalid1          (rvalid1),
        .err0             (err0),
        .err1             (err1),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    // Memory preloads to 0xA500_0000 | index so every word is distinguishable.
    always_ff @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
        end else if (mem_write_enable) begin
            mem[mem_address[7:0]] <= mem_write_data;
        end
    end

    assign mem_read_data = mem[mem_address[7:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; mem_clr = 1'b1;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
        addr0 = 32'd1; addr1 = 32'd2; wdata0 = 32'h1111_1111; wdata1 = 32'h2222_2222;
        #1;
        step();
        mem_clr = 1'b0;
        step();
        #1;
        // Reset held with both ports requesting stores.
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_we", mem_write_enable, 0);
        check("rst_rvalid0", rvalid0, 0);
        check("rst_rvalid1", rvalid1, 0);
        check("rst_err0", err0, 0);
        check("rst_err1", err1, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0);
        check("rst_mem1", mem[1], 32'hA500_0001);

        // Contention: both ports load continuously for 6 cycles.
        rst = 1'b0; we0 = 1'b0; we1 = 1'b0; addr0 = 32'd3; addr1 = 32'd4;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("cont_gnt0_%0d", i), gnt0, (i % 2 == 0));
            check($sformatf("cont_gnt1_%0d", i), gnt1, (i % 2 == 1));
            check($sformatf("cont_rv0_%0d", i), rvalid0, (i % 2 == 1));
            check($sformatf("cont_rv1_%0d", i), rvalid1, (i > 0 && i % 2 == 0));
            if (i % 2 == 1) check($sformatf("cont_rd0_%0d", i), rdata0, 32'hA500_0003);
            if (i > 0 && i % 2 == 0) check($sformatf("cont_rd1_%0d", i), rdata1, 32'hA500_0004);
            step();
        end
        req0 = 1'b0; req1 = 1'b0;
        #1;
        check("cont_last_rv1", rvalid1, 1);
        check("cont_last_rv0", rvalid0, 0);
        check("cont_last_rd1", rdata1, 32'hA500_0004);

        // Port 1 store then load at addr 5.
        step();
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd5; wdata1 = 32'hDEAD_BEEF;
        #1;
        check("st_gnt1", gnt1, 1);
        check("st_we", mem_write_enable, 1);
        check("st_addr", mem_address, 32'd5);
        check("st_wdata", mem_write_data, 32'hDEAD_BEEF);
        step();
        we1 = 1'b0;
        #1;
        check("st_rv1", rvalid1, 1);
        check("st_err1", err1, 0);
        check("st_rd1", rdata1, 0);
        check("ld_gnt1_b2b", gnt1, 1);
        check("ld_we", mem_write_enable, 0);
        step();
        req1 = 1'b0;
        #1;
        check("ld_rv1", rvalid1, 1);
        check("ld_err1", err1, 0);
        check("ld_rd1", rdata1, 32'hDEAD_BEEF);

        // Out-of-range store from port 0, then port 1 loads addr 0.
        step();
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd256; wdata0 = 32'h0000_1234;
        #1;
        check("oor_gnt0", gnt0, 1);
        check("oor_we", mem_write_enable, 0);
        step();
        req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 32'd0;
        #1;
        check("oor_rv0", rvalid0, 1);
        check("oor_err0", err0, 1);
        check("oor_rd0", rdata0, 0);
        check("oor_gnt1", gnt1, 1);
        step();
        req1 = 1'b0;
        #1;
        check("oor_rd1", rdata1, 32'hA500_0000);
        check("oor_err1", err1, 0);

        // Boundary: store/load at 255, load at 0x100000FF.
        step();
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd255; wdata0 = 32'hCAFE_F00D;
        #1;
        check("b255_we", mem_write_enable, 1);
        step();
        we0 = 1'b0;
        #1;
        check("b255_st_err", err0, 0);
        step();
        addr0 = 32'h1000_00FF;
        #1;
        check("b255_ld_rd", rdata0, 32'hCAFE_F00D);
        check("b255_ld_err", err0, 0);
        check("bhi_gnt0", gnt0, 1);
        step();
        req0 = 1'b0;
        #1;
        check("bhi_rv0", rvalid0, 1);
        check("bhi_err0", err0, 1);
        check("bhi_rd0", rdata0, 0);

        // Reset lands while port 1 store to addr 7 is granted (last_gnt is 0 here).
        step();
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd7; wdata1 = 32'h7777_7777;
        #1;
        check("mrst_pre_gnt1", gnt1, 1);
        rst = 1'b1;
        #1;
        check("mrst_gnt1", gnt1, 0);
        check("mrst_we", mem_write_enable, 0);
        step();
        rst = 1'b0;
        req1 = 1'b0;
        #1;
        check("mrst_rv1", rvalid1, 0);
        check("mrst_rd1", rdata1, 0);
        check("mrst_mem7", mem[7], 32'hA500_0007);
        step();
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 32'd7; addr1 = 32'd7;
        #1;
        check("mrst_gnt0_first", gnt0, 1);
        check("mrst_gnt1_first", gnt1, 0);
        step();
        req0 = 1'b0; req1 = 1'b0;
        #1;
        check("mrst_rd0_mem7", rdata0, 32'hA500_0007);

        // Reset with last_gnt = 0 and no request pending must restore port 0 priority.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        #1;
        check("rst2_gnt0", gnt0, 1);
        check("rst2_gnt1", gnt1, 0);
        step();
        req0 = 1'b0; req1 = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
